// File: rtl/spare_candidate_generator.sv
// Spare candidate generator for the redundancy analyser.
// Walks every (DSSS, RLSS) pair where each word has a fixed popcount.
// RLSS is the inner loop and DSSS is the outer loop.
// Each pair is offered once through a valid/ready handshake, with no bubbles.

// Next larger integer with the same popcount (Gosper's step), purely combinational.
// The result is meaningless for the highest legal word, so the caller wraps instead.
module spare_candidate_generator_next #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);

    logic [W-1:0] lsb;
    logic [W-1:0] ripple;
    logic [W-1:0] changed;
    int           tz;

    // lowest set bit, carry it upward, then right-justify the displaced ones
    always_comb begin
        lsb     = cur & (~cur + W'(1));
        ripple  = cur + lsb;
        changed = (cur ^ ripple) >> 2;
        // unrolled priority encoder: count of trailing zeros of cur
        tz = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (cur[i]) begin
                tz = i;
            end
        end
        nxt = ripple | (changed >> tz);
    end

endmodule

module spare_candidate_generator #(
    parameter int DSSS_W    = 8,
    parameter int DSSS_ONES = 4,
    parameter int RLSS_W    = 4,
    parameter int RLSS_ONES = 2,
    parameter int IDX_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DSSS_W-1:0] dsss,
    output logic [RLSS_W-1:0] rlss,
    output logic [IDX_W-1:0]  cand_idx,
    output logic              last,
    output logic              busy,
    output logic              done
);

    // lowest legal word has its ones packed at the bottom, highest at the top
    localparam logic [DSSS_W-1:0] DSSS_LO = DSSS_W'((64'd1 << DSSS_ONES) - 64'd1);
    localparam logic [DSSS_W-1:0] DSSS_HI = DSSS_LO << (DSSS_W - DSSS_ONES);
    localparam logic [RLSS_W-1:0] RLSS_LO = RLSS_W'((64'd1 << RLSS_ONES) - 64'd1);
    localparam logic [RLSS_W-1:0] RLSS_HI = RLSS_LO << (RLSS_W - RLSS_ONES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [DSSS_W-1:0]   dsss_q,      dsss_d;
    logic [RLSS_W-1:0]   rlss_q,      rlss_d;
    logic [IDX_W-1:0]    cand_idx_q,  cand_idx_d;

    logic [DSSS_W-1:0]   dsss_next;
    logic [RLSS_W-1:0]   rlss_next;
    logic                dsss_at_hi;
    logic                rlss_at_hi;
    logic                last_w;
    logic                handshake;

    spare_candidate_generator_next #(.W(DSSS_W)) u_dsss_next (
        .cur (dsss_q),
        .nxt (dsss_next)
    );

    spare_candidate_generator_next #(.W(RLSS_W)) u_rlss_next (
        .cur (rlss_q),
        .nxt (rlss_next)
    );

    // final-candidate detection and handshake from registered state only
    always_comb begin
        dsss_at_hi = (dsss_q == DSSS_HI);
        rlss_at_hi = (rlss_q == RLSS_HI);
        // qualified by valid so that the held final words do not flag last while idle
        last_w     = out_valid_q & dsss_at_hi & rlss_at_hi;
        handshake  = out_valid_q & out_ready;
    end

    // sweep sequencing: next state, next candidate and registered outputs
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dsss_d      = dsss_q;
        rlss_d      = rlss_q;
        cand_idx_d  = cand_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    dsss_d      = DSSS_LO;
                    rlss_d      = RLSS_LO;
                    cand_idx_d  = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // abort beats a simultaneous handshake and suppresses done
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (handshake) begin
                    if (last_w) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        cand_idx_d = cand_idx_q + IDX_W'(1);
                        if (rlss_at_hi) begin
                            rlss_d = RLSS_LO;
                            dsss_d = dsss_next;
                        end else begin
                            rlss_d = rlss_next;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dsss_q      <= '0;
            rlss_q      <= '0;
            cand_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dsss_q      <= dsss_d;
            rlss_q      <= rlss_d;
            cand_idx_q  <= cand_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dsss      = dsss_q;
    assign rlss      = rlss_q;
    assign cand_idx  = cand_idx_q;
    assign last      = last_w;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
